// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: one request at a time against a combinational big-endian
// word RAM. Sub-word stores are performed as read-modify-write.
module mem_stage_lsu #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic [4:0]        resp_rd,
  output logic              resp_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_read,
  output logic              ram_write,
  input  logic [31:0]       ram_rdata
);

  localparam logic [1:0] SzByte = 2'b00;
  localparam logic [1:0] SzHalf = 2'b01;
  localparam logic [1:0] SzWord = 2'b10;

  typedef enum logic [2:0] {StIdle, StRd, StRmwRd, StWr, StResp} state_e;

  state_e            state_q, state_d;
  logic [1:0]        size_q;
  logic              unsigned_q;
  logic [1:0]        off_q;
  logic [15:0]       wdata_q;
  logic [4:0]        rd_q;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]       ram_wdata_q, ram_wdata_d;

  logic        accept;
  logic        req_bad;
  logic [4:0]  lane_shamt;
  logic [15:0] lane_half;
  logic [31:0] lane_mask;
  logic [31:0] load_ext;
  logic [31:0] merge_word;

  assign accept  = req_valid && (state_q == StIdle);
  assign req_bad = (req_size == 2'b11) ||
                   ((req_size == SzHalf) && req_addr[0]) ||
                   ((req_size == SzWord) && (req_addr[1:0] != 2'b00));

  // Lane 0 is the most significant byte, so the shift grows as the offset shrinks.
  always_comb begin
    lane_shamt = 5'd0;
    if (size_q == SzByte) begin
      lane_shamt = {~off_q, 3'b000};
    end else if (!off_q[1]) begin
      lane_shamt = 5'd16;
    end
    lane_half  = 16'(ram_rdata >> lane_shamt);
    lane_mask  = ((size_q == SzByte) ? 32'h0000_00ff : 32'h0000_ffff) << lane_shamt;
    merge_word = (ram_rdata & ~lane_mask) | (({16'h0000, wdata_q} << lane_shamt) & lane_mask);
    case (size_q)
      SzByte:  load_ext = {{24{~unsigned_q & lane_half[7]}}, lane_half[7:0]};
      SzHalf:  load_ext = {{16{~unsigned_q & lane_half[15]}}, lane_half};
      default: load_ext = ram_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          err_d   = req_bad;
          rdata_d = 32'h0;
          if (req_bad) begin
            state_d = StResp;
          end else begin
            ram_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
            if (!req_we) begin
              state_d = StRd;
            end else if (req_size == SzWord) begin
              ram_wdata_d = req_wdata;
              state_d     = StWr;
            end else begin
              state_d = StRmwRd;
            end
          end
        end
      end
      StRd: begin
        rdata_d = load_ext;
        state_d = StResp;
      end
      StRmwRd: begin
        ram_wdata_d = merge_word;
        state_d     = StWr;
      end
      StWr: begin
        state_d = StResp;
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      size_q      <= 2'b00;
      unsigned_q  <= 1'b0;
      off_q       <= 2'b00;
      wdata_q     <= 16'h0;
      rd_q        <= 5'd0;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      if (accept) begin
        size_q     <= req_size;
        unsigned_q <= req_unsigned;
        off_q      <= req_addr[1:0];
        wdata_q    <= req_wdata[15:0];
        rd_q       <= req_rd;
      end
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = rdata_q;
  assign resp_rd    = rd_q;
  assign resp_err   = err_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign ram_read   = (state_q == StRd) || (state_q == StRmwRd);
  assign ram_write  = (state_q == StWr);

endmodule

// File: doc/mem_stage_lsu.md
MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, byte-address width shared with the data RAM.
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  in  1  memory-stage request present.
REQ-005 SHALL have port req_ready  out  1  request accepted when req_valid&req_ready at a rising edge.
REQ-006 SHALL have port req_we  in  1  1=store, 0=load.
REQ-007 SHALL have port req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 SHALL have port req_unsigned  in  1  loads only: zero-extend (1) or sign-extend (0).
REQ-009 SHALL have port req_addr  in  ADDR_W  byte address.
REQ-010 SHALL have port req_wdata  in  32  store data, right-justified.
REQ-011 SHALL have port req_rd  in  5  destination register tag, returned unchanged.
REQ-012 SHALL have port resp_valid  out  1  response present; held until resp_ready.
REQ-013 SHALL have port resp_ready  in  1  consumer accepts the response.
REQ-014 SHALL have port resp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-015 SHALL have port resp_rd  out  5  tag of the request that produced the response.
REQ-016 SHALL have port resp_err  out  1  misaligned or illegal-size request.
REQ-017 SHALL have ports ram_addr out ADDR_W, ram_wdata out 32, ram_read out 1, ram_write out 1, ram_rdata in 32, which drive the combinational big-endian byte RAM.

Function
REQ-018 SHALL implement the states IDLE, RD, RMW_RD, WR, RESP.
REQ-019 SHALL drive req_ready=1 only in IDLE.
REQ-020 SHALL decode every accepted request in IDLE as follows:
- size 11, half with addr[0]=1, or word with addr[1:0]!=0 -> RESP with resp_err=1, no RAM access.
- load -> RD.
- SW -> WR.
- SB or SH -> RMW_RD.
REQ-021 SHALL always drive ram_addr = {addr[ADDR_W-1:2],2'b00}; the RAM is never accessed unaligned, so no address wrap occurs.
REQ-022 SHALL assert ram_read=1 only in RD and RMW_RD, and capture ram_rdata at the end of that cycle.
REQ-023 SHALL assert ram_write=1 only in WR, for exactly one cycle, with ram_addr and ram_wdata stable for that whole cycle.
REQ-024 SHALL never assert ram_read and ram_write together; in all other states both are 0, and ram_wdata and ram_addr hold their last value.
REQ-025 SHALL use big-endian byte lanes, with lane k = addr[1:0] and k=0 mapping to bits [31:24]; a half at offset 0 uses [31:16] and a half at offset 2 uses [15:0].
REQ-026 SHALL extend loaded bytes and halves to 32 bits per req_unsigned; LW returns the word as read.
REQ-027 SHALL form the SB/SH write word as the RMW_RD captured word with only the addressed lane(s) replaced by req_wdata[7:0] or [15:0]; SW writes req_wdata unchanged.
REQ-028 SHALL meet the following latency, counting acceptance at edge N:
- error -> resp_valid in cycle N+1.
- load, SW -> resp_valid in cycle N+2.
- SB, SH -> resp_valid in cycle N+3.
REQ-029 SHALL hold RESP, with resp_* stable, while resp_ready=0; on resp_valid&resp_ready it SHALL return to IDLE (no same-cycle re-accept).
REQ-030 SHALL register request fields at acceptance; input changes after acceptance have no effect.
REQ-031 SHALL give each state the following single successor: RD->RESP; RMW_RD->WR; WR->RESP.

Reset
REQ-032 SHALL, with rst_n=0, immediately and asynchronously force state IDLE and the output values: req_ready=1 once released; resp_valid=0, resp_err=0, resp_rdata=0, resp_rd=0, ram_read=0, ram_write=0, ram_addr=0, ram_wdata=0.
REQ-033 SHALL, on reset in any state including RMW_RD or WR, drop the in-flight request with no RAM write after reset assertion and no response issued.
REQ-034 SHALL accept the first request no earlier than the first rising edge after rst_n deasserts.

Verification
REQ-035 SHALL cover: RAM 0x10..0x13 = 88 99 AA BB; LB 0x11 -> resp_rdata=0xFFFFFF99 at N+2; LBU 0x11 -> 0x00000099; LHU 0x12 -> 0x0000AABB.
REQ-036 SHALL cover: SB addr 0x12 with wdata=0x000000CC -> ram_read in N+1, ram_write for one cycle in N+2 with addr 0x10 and data 0x8899CCBB; resp_valid at N+3 with resp_rdata=0.
REQ-037 SHALL cover: LW 0x13 or SH 0x11 -> resp_err=1 at N+1, with no ram_read/ram_write pulse; size=11 -> same.
REQ-038 SHALL cover: LW 0x10 with resp_ready=0 for 3 cycles -> resp_valid and 0x8899AABB held, req_ready=0, RAM idle; returns to IDLE the cycle after resp_ready=1.
REQ-039 SHALL cover: rst_n pulsed low during RMW_RD of an SH -> no ram_write, all outputs 0, RAM contents unchanged, next request served normally.
REQ-040 SHALL cover: back-to-back SW 0x20=0x11223344 then LW 0x20 -> load returns 0x11223344 and resp_rd matches each request's tag.
